fetch_unit: RTL and testbench

Instruction fetch front-end sitting directly upstream of the IF pipeline register. It owns the fetch program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. It supplies the next {PC, instruction} pair to IF each cycle. On a taken branch or jump it redirects fetch, flushes the FIFO and drops in-flight responses.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end upstream of the IF pipeline register.
//
// Owns the fetch PC, issues in-order word requests to instruction memory
// (req/gnt, in-order rvalid responses) and buffers returned words with their
// PCs in a DEPTH-entry prefetch FIFO. The FIFO head is presented to IF each
// cycle. A redirect flushes the FIFO, restarts fetch at redirect_pc and marks
// every response still in flight for discard.
//
// Ports
//   Clock, nReset          rising-edge clock, async active-low reset
//   redirect, redirect_pc  taken branch/jump from EX and its target
//   hold                   downstream stall, head entry is not consumed
//   imem_req/addr/gnt      request channel (addr held until gnt)
//   imem_rvalid/rdata      response channel, in request order
//   fetch_valid            head entry present (0 -> IF inserts a bubble)
//   PC, instruction        head entry, or 0 / NOP when empty
//
// fetch_fifo: circular buffer of {pc, instr} pairs with flush and count.

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Storage carries no reset; count gates every read.
  always_ff @(posedge Clock) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]  <= push_pc;
      ins_mem[wr_ptr] <= push_instr;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = ins_mem[rd_ptr];

endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] PC,
  output logic [31:0] instruction
);

  localparam int          CW  = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic          run;
  logic [31:0]   head_pc, head_instr;
  logic [31:0]   redirect_base;
  logic [CW:0]   in_use;
  logic          issue, rsp, keep, push, pop;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  // Buffered plus in-flight words may never exceed DEPTH; this is what
  // guarantees every accepted response has a FIFO slot. In-flight requests
  // from before a redirect still occupy the budget until they drain.
  assign in_use   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = run && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign issue = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error; ignore it.
  assign rsp   = imem_rvalid && (outstanding != '0);
  assign keep  = rsp && (discard == '0);
  assign push  = keep && !redirect;
  assign pop   = fetch_valid && !hold && !redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock      (Clock),
    .nReset     (nReset),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_pc    (resp_pc),
    .push_instr (imem_rdata),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      // issue is forced low during redirect, so this covers both cases.
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        // Everything still in flight after this edge belongs to the old path.
        discard  <= outstanding - CW'(rsp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  assign fetch_valid = (count != '0);
  assign PC          = fetch_valid ? head_pc    : 32'h0;
  assign instruction = fetch_valid ? head_instr : NOP;

  a_rvalid_with_outstanding: assert property (
    @(posedge Clock) disable iff (!nReset) !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC=0x100, DEPTH=2). A fixed-latency
// memory responder returns word_of(addr) for each granted request; every
// cycle's expected req/addr/valid/PC is written out by hand in the steps.
module tb_fetch_unit;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_valid;
  logic [31:0] PC;
  logic [31:0] instruction;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .PC          (PC),
    .instruction (instruction)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},   32'(imem_req), 32'h0);
    chk({tag, ".addr"},  imem_addr, 32'h0000_0100);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, ".pc"},    PC, 32'h0);
    chk({tag, ".instr"}, instruction, 32'h0000_0013);
  endtask

  // One clock cycle: drive inputs (memory response from the queue), check the
  // settled outputs, record a grant, then advance past the next rising edge.
  task automatic step(input string tag, input logic g, input logic h, input logic r,
                      input logic [31:0] rp, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epc);
    imem_gnt = g; hold = h; redirect = r; redirect_pc = rp;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(ereq));
    if (ereq) chk({tag, ".addr"}, imem_addr, eaddr);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'(ev));
    chk({tag, ".pc"},    PC, ev ? epc : 32'h0);
    chk({tag, ".instr"}, instruction, ev ? word_of(epc) : 32'h0000_0013);
    if (imem_req && imem_gnt) mq.push_back('{cyc + lat, imem_addr});
    @(posedge Clock); #1;
    cyc++;
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk_reset("rst");
    nReset = 1'b1;

    // Reset release, 1-cycle memory, zero-wait grant. With DEPTH=2 the cap
    // gives a valid,valid,bubble cadence.
    step("c0",  1,0,0,32'h0, 0,32'h0,   0,32'h0);
    step("c1",  1,0,0,32'h0, 1,32'h100, 0,32'h0);
    step("c2",  1,0,0,32'h0, 1,32'h104, 0,32'h0);
    step("c3",  1,0,0,32'h0, 0,32'h0,   1,32'h100);
    step("c4",  1,0,0,32'h0, 1,32'h108, 1,32'h104);
    step("c5",  1,0,0,32'h0, 1,32'h10C, 0,32'h0);
    step("c6",  1,0,0,32'h0, 0,32'h0,   1,32'h108);
    step("c7",  1,0,0,32'h0, 1,32'h110, 1,32'h10C);
    step("c8",  1,0,0,32'h0, 1,32'h114, 0,32'h0);
    step("c9",  1,0,0,32'h0, 0,32'h0,   1,32'h110);

    // hold for 5 cycles: head frozen, requests stop at count+outstanding=2.
    step("h0",  1,1,0,32'h0, 1,32'h118, 1,32'h114);
    step("h1",  1,1,0,32'h0, 0,32'h0,   1,32'h114);
    step("h2",  1,1,0,32'h0, 0,32'h0,   1,32'h114);
    step("h3",  1,1,0,32'h0, 0,32'h0,   1,32'h114);
    step("h4",  1,1,0,32'h0, 0,32'h0,   1,32'h114);
    step("h5",  1,0,0,32'h0, 0,32'h0,   1,32'h114);
    step("h6",  1,0,0,32'h0, 1,32'h11C, 1,32'h118);
    step("h7",  1,0,0,32'h0, 1,32'h120, 0,32'h0);
    step("h8",  1,0,0,32'h0, 0,32'h0,   1,32'h11C);

    // Grant stall of 4 cycles: address held, fetch_pc moves only on grant.
    step("g0",  0,0,0,32'h0, 1,32'h124, 1,32'h120);
    step("g1",  0,0,0,32'h0, 1,32'h124, 0,32'h0);
    step("g2",  0,0,0,32'h0, 1,32'h124, 0,32'h0);
    step("g3",  0,0,0,32'h0, 1,32'h124, 0,32'h0);
    step("g4",  1,0,0,32'h0, 1,32'h124, 0,32'h0);
    step("g5",  1,0,0,32'h0, 1,32'h128, 0,32'h0);
    step("g6",  1,0,0,32'h0, 0,32'h0,   1,32'h124);
    step("g7",  0,0,0,32'h0, 1,32'h12C, 1,32'h128);

    // 3-cycle memory, redirect to 0x2002 with two requests outstanding.
    lat = 3;
    step("r0",  1,0,0,32'h0,    1,32'h12C,  0,32'h0);
    step("r1",  1,0,0,32'h0,    1,32'h130,  0,32'h0);
    step("r2",  1,0,1,32'h2002, 0,32'h0,    0,32'h0);
    step("r3",  1,0,0,32'h0,    0,32'h0,    0,32'h0);
    step("r4",  1,0,0,32'h0,    1,32'h2000, 0,32'h0);
    step("r5",  1,0,0,32'h0,    1,32'h2004, 0,32'h0);
    step("r6",  1,0,0,32'h0,    0,32'h0,    0,32'h0);
    step("r7",  1,0,0,32'h0,    0,32'h0,    0,32'h0);
    step("r8",  0,0,0,32'h0,    0,32'h0,    1,32'h2000);
    step("r9",  0,0,0,32'h0,    1,32'h2008, 1,32'h2004);

    // Reset asserted mid-operation clears state at once.
    nReset = 1'b0;
    #1;
    chk_reset("rst2");
    lat = 1;
    @(posedge Clock); #1;
    cyc++;
    nReset = 1'b1;

    // Redirect together with rvalid and hold, then a redirect that withdraws
    // a live request, then the 0xFFFF_FFFC -> 0 wrap.
    step("s0",  1,0,0,32'h0,         0,32'h0,         0,32'h0);
    step("s1",  1,0,0,32'h0,         1,32'h100,       0,32'h0);
    step("s2",  1,0,0,32'h0,         1,32'h104,       0,32'h0);
    step("s3",  1,1,1,32'h3002,      0,32'h0,         1,32'h100);
    step("s4",  1,0,0,32'h0,         1,32'h3000,      0,32'h0);
    step("s5",  1,0,0,32'h0,         1,32'h3004,      0,32'h0);
    step("s6",  1,0,0,32'h0,         0,32'h0,         1,32'h3000);
    step("s7",  1,0,1,32'hFFFF_FFFC, 0,32'h0,         1,32'h3004);
    step("s8",  1,0,0,32'h0,         1,32'hFFFF_FFFC, 0,32'h0);
    step("s9",  1,0,0,32'h0,         1,32'h0,         0,32'h0);
    step("s10", 1,0,0,32'h0,         0,32'h0,         1,32'hFFFF_FFFC);
    step("s11", 0,0,0,32'h0,         1,32'h4,         1,32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
